fu_out_queue: RTL and testbench
===============================

FU_OUT_QUEUE -- requirements
Module: fu_out_queue

Interface
REQ-001 Parameter DEPTH, default 2, sets the number of result entries; legal values are 2, 4 and 8.
REQ-002 Parameter TAG_W, default 6, sets the physical-register tag width.
REQ-003 Parameter DATA_W, default 32, sets the result value width.
REQ-004 Parameter STARVE_LIMIT, default 4, sets the wait-cycle threshold for the urgent flag.
REQ-005 Port clock, input, 1 bit: system clock; all state updates on its posedge.
REQ-006 Port reset, input, 1 bit: reset, synchronous, active-high; clock is clock.
REQ-007 Port in_valid, input, 1 bit: functional-unit (FU) pipeline presents a completed result.
REQ-008 Port in_tag, input, TAG_W bits: destination tag of the incoming result.
REQ-009 Port in_value, input, DATA_W bits: incoming result value.
REQ-010 Port in_ready, output, 1 bit: queue can accept a result this cycle.
REQ-011 Port squash, input, 1 bit: branch-mispredict flush.
REQ-012 Port result_valid, output, 1 bit: request to the CDB selector; one bit of its fu_result_valid vector.
REQ-013 Port result_tag, output, TAG_W bits: tag of the head entry.
REQ-014 Port result_value, output, DATA_W bits: value of the head entry.
REQ-015 Port grant, input, 1 bit: this FU's one-hot bit from the selector's selection.
REQ-016 Port count, output, $clog2(DEPTH+1) bits: number of occupied entries.
REQ-017 Port urgent, output, 1 bit: the head entry is starving.
REQ-018 Port drop_err, output, 1 bit: sticky flag; a result was offered while the queue was full.

Function
REQ-019 Storage is a circular FIFO with head/tail pointers that wrap modulo DEPTH, plus an occupancy counter.
REQ-020 in_ready = (count < DEPTH); it depends only on registered state and never on grant.
REQ-021 Push occurs when in_valid && in_ready; the entry is written at the tail, and the tail pointer and count advance at the next posedge.
REQ-022 Pop occurs when grant && result_valid; the head pointer advances and count decrements at the next posedge.
REQ-023 A grant while result_valid=0 is ignored, with no state change.
REQ-024 Simultaneous push and pop leaves count unchanged, and both pointers advance.
REQ-025 result_valid = (count != 0); result_tag and result_value are read from the head entry and are registered state only.
REQ-026 Latency: a result pushed into an empty queue appears on result_valid exactly 1 cycle after the push cycle.
REQ-027 When count = DEPTH, in_valid=1 and in_ready=0: the result is dropped, no state changes, and drop_err sets at the next posedge.
REQ-028 squash=1: at the next posedge count=0, head=tail=0 and urgent=0; squash overrides any same-cycle push or pop; drop_err is unaffected.
REQ-029 Results leave strictly in push order, with no reordering.

Configuration
REQ-030 Macro FU_OUT_STARVE_EN, when defined, enables a wait counter of $clog2(STARVE_LIMIT+1) bits.
REQ-031 With FU_OUT_STARVE_EN: the wait counter increments each cycle that result_valid && !grant, saturating at STARVE_LIMIT.
REQ-032 With FU_OUT_STARVE_EN: the wait counter clears on pop or squash, and urgent = (wait counter == STARVE_LIMIT).
REQ-033 Without FU_OUT_STARVE_EN: no wait counter is instantiated and urgent is tied to 0.

Reset
REQ-034 On reset, count=0, head=0, tail=0, result_valid=0, in_ready=1, urgent=0, drop_err=0 and the wait counter=0.
REQ-035 On reset, entry contents are don't-care, and result_tag/result_value drive 0 while count=0.
REQ-036 Reset has priority over squash, push and pop.
REQ-037 Reset asserted mid-operation discards all entries at the next posedge.

Verification
REQ-038 Reset, then push tag=5/value=0x11 at cycle 1 -> result_valid=1, result_tag=5 at cycle 2; grant at cycle 2 -> count=0 at cycle 3.
REQ-039 DEPTH=2: push tags 1, 2, 3 on consecutive cycles with no grant -> tag 3 is dropped, drop_err=1, count=2; then grants pop tag 1 followed by tag 2.
REQ-040 count=1: push and grant in the same cycle -> count stays 1 and the head becomes the new tag.
REQ-041 count=2: squash together with in_valid and grant -> count=0 and result_valid=0 on the next cycle.
REQ-042 FU_OUT_STARVE_EN, STARVE_LIMIT=4: hold one entry without grant -> urgent=1 on the 5th cycle after push, stays 1, and clears the cycle after grant.
REQ-043 Wrap-around at DEPTH=4: perform 10 push/pop pairs -> output order matches input order and pointers wrap without error.

Source files
------------

// File: rtl/fu_out_queue.sv
// Per-FU result queue feeding one request bit of the CDB selector; a circular FIFO popped on grant.
// Define FU_OUT_STARVE_EN to add a head-entry wait counter driving the urgent flag.
module fu_out_queue #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned TAG_W        = 6,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic [DATA_W-1:0]          in_value,
    output logic                       in_ready,
    input  logic                       squash,
    output logic                       result_valid,
    output logic [TAG_W-1:0]           result_tag,
    output logic [DATA_W-1:0]          result_value,
    input  logic                       grant,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       urgent,
    output logic                       drop_err
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = $clog2(DEPTH);

    if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_bad_depth
        $error("fu_out_queue: DEPTH must be 2, 4 or 8");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("fu_out_queue: STARVE_LIMIT must be at least 1");
    end

    logic [TAG_W-1:0]  tag_q   [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            drop_q, drop_d;
    logic            push, pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign in_ready     = (count_q < CntW'(DEPTH));
    assign result_valid = (count_q != '0);
    assign push         = in_valid && in_ready;
    assign pop          = grant && result_valid;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        // Offering a result to a full queue latches the error even across a squash.
        drop_d  = drop_q | (in_valid & ~in_ready);
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = next_ptr(tail_q);
            if (pop)  head_d = next_ptr(head_q);
            if (push && !pop)      count_d = count_q + CntW'(1);
            else if (!push && pop) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Entry storage needs no reset; empty-queue outputs are forced to zero below.
    always_ff @(posedge clock) begin
        if (!reset && !squash && push) begin
            tag_q[tail_q]   <= in_tag;
            value_q[tail_q] <= in_value;
        end
    end

    assign result_tag   = result_valid ? tag_q[head_q]   : '0;
    assign result_value = result_valid ? value_q[head_q] : '0;
    assign count        = count_q;
    assign drop_err     = drop_q;

`ifdef FU_OUT_STARVE_EN
    localparam int unsigned WaitW = $clog2(STARVE_LIMIT + 1);

    logic [WaitW-1:0] wait_q, wait_d;

    always_comb begin
        wait_d = wait_q;
        if (squash || pop) begin
            wait_d = '0;
        end else if (result_valid && !grant && (wait_q != WaitW'(STARVE_LIMIT))) begin
            wait_d = wait_q + WaitW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) wait_q <= '0;
        else       wait_q <= wait_d;
    end

    assign urgent = (wait_q == WaitW'(STARVE_LIMIT));
`else
    assign urgent = 1'b0;
`endif

endmodule

// File: tb/tb_fu_out_queue.sv
// Directed bench for fu_out_queue: a DEPTH=2 instance driven from a vector table plus
// hand-written reset/starvation sequences, and a DEPTH=4 instance for pointer wrap-around.
module tb_fu_out_queue;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // DEPTH=2 instance
    logic        a_in_valid = 1'b0, a_squash = 1'b0, a_grant = 1'b0;
    logic [5:0]  a_in_tag = '0;
    logic [31:0] a_in_value = '0;
    logic        a_in_ready, a_valid, a_urgent, a_drop;
    logic [5:0]  a_tag;
    logic [31:0] a_value;
    logic [1:0]  a_count;

    fu_out_queue #(.DEPTH(2), .TAG_W(6), .DATA_W(32), .STARVE_LIMIT(4)) u_dut_a (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (a_in_valid),
        .in_tag       (a_in_tag),
        .in_value     (a_in_value),
        .in_ready     (a_in_ready),
        .squash       (a_squash),
        .result_valid (a_valid),
        .result_tag   (a_tag),
        .result_value (a_value),
        .grant        (a_grant),
        .count        (a_count),
        .urgent       (a_urgent),
        .drop_err     (a_drop)
    );

    // DEPTH=4 instance
    logic        b_in_valid = 1'b0, b_squash = 1'b0, b_grant = 1'b0;
    logic [5:0]  b_in_tag = '0;
    logic [31:0] b_in_value = '0;
    logic        b_in_ready, b_valid, b_urgent, b_drop;
    logic [5:0]  b_tag;
    logic [31:0] b_value;
    logic [2:0]  b_count;

    fu_out_queue #(.DEPTH(4), .TAG_W(6), .DATA_W(32), .STARVE_LIMIT(4)) u_dut_b (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (b_in_valid),
        .in_tag       (b_in_tag),
        .in_value     (b_in_value),
        .in_ready     (b_in_ready),
        .squash       (b_squash),
        .result_valid (b_valid),
        .result_tag   (b_tag),
        .result_value (b_value),
        .grant        (b_grant),
        .count        (b_count),
        .urgent       (b_urgent),
        .drop_err     (b_drop)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic [5:0]  tag;
        logic [31:0] val;
        logic        sq;
        logic        gr;
        logic        ev;
        logic [5:0]  etag;
        logic [31:0] evalue;
        logic [1:0]  ecnt;
        logic        erdy;
        logic        edrop;
    } vec_t;

    vec_t vecs[$];

    // Expected fields describe the outputs seen during the row, before its inputs take effect.
    task automatic add(input logic iv, input logic [5:0] tag, input logic [31:0] val,
                       input logic sq, input logic gr, input logic ev, input logic [5:0] etag,
                       input logic [31:0] evalue, input logic [1:0] ecnt, input logic erdy,
                       input logic edrop);
        vec_t v;
        v.iv = iv; v.tag = tag; v.val = val; v.sq = sq; v.gr = gr;
        v.ev = ev; v.etag = etag; v.evalue = evalue; v.ecnt = ecnt;
        v.erdy = erdy; v.edrop = edrop;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] vv(input int t);
        return 32'hA000_0000 | 32'(t);
    endfunction

    initial begin
        logic [5:0]  sb_tag[$];
        logic [31:0] sb_val[$];
        int          exp_cnt;
        int          pops;
        logic        do_push, do_pop;

        //  iv tag val       sq gr   ev etag evalue    cnt rdy drop
        add(0, 0,  0,        0, 0,   0, 0,  0,        0, 1, 0);  // reset state
        add(1, 5,  32'h11,   0, 0,   0, 0,  0,        0, 1, 0);  // push into empty
        add(0, 0,  0,        0, 1,   1, 5,  32'h11,   1, 1, 0);  // visible next cycle, grant
        add(0, 0,  0,        0, 0,   0, 0,  0,        0, 1, 0);
        add(1, 1,  vv(1),    0, 0,   0, 0,  0,        0, 1, 0);
        add(1, 2,  vv(2),    0, 0,   1, 1,  vv(1),    1, 1, 0);
        add(1, 3,  vv(3),    0, 0,   1, 1,  vv(1),    2, 0, 0);  // full: tag 3 dropped
        add(0, 0,  0,        0, 0,   1, 1,  vv(1),    2, 0, 1);
        add(0, 0,  0,        0, 1,   1, 1,  vv(1),    2, 0, 1);  // pop tag 1
        add(0, 0,  0,        0, 1,   1, 2,  vv(2),    1, 1, 1);  // pop tag 2
        add(0, 0,  0,        0, 1,   0, 0,  0,        0, 1, 1);  // grant while empty ignored
        add(0, 0,  0,        0, 0,   0, 0,  0,        0, 1, 1);
        add(1, 7,  vv(7),    0, 0,   0, 0,  0,        0, 1, 1);
        add(1, 8,  vv(8),    0, 1,   1, 7,  vv(7),    1, 1, 1);  // push+pop at count 1
        add(0, 0,  0,        0, 0,   1, 8,  vv(8),    1, 1, 1);
        add(0, 0,  0,        0, 1,   1, 8,  vv(8),    1, 1, 1);
        add(0, 0,  0,        0, 0,   0, 0,  0,        0, 1, 1);
        add(1, 9,  vv(9),    0, 0,   0, 0,  0,        0, 1, 1);
        add(1, 10, vv(10),   0, 0,   1, 9,  vv(9),    1, 1, 1);
        add(1, 11, vv(11),   1, 1,   1, 9,  vv(9),    2, 0, 1);  // squash beats push/pop
        add(0, 0,  0,        0, 0,   0, 0,  0,        0, 1, 1);
        add(1, 12, vv(12),   0, 0,   0, 0,  0,        0, 1, 1);
        add(0, 0,  0,        0, 0,   1, 12, vv(12),   1, 1, 1);
        add(0, 0,  0,        0, 1,   1, 12, vv(12),   1, 1, 1);
        add(0, 0,  0,        0, 0,   0, 0,  0,        0, 1, 1);

        step();
        step();
        reset = 1'b0;

        foreach (vecs[i]) begin
            a_in_valid = vecs[i].iv;
            a_in_tag   = vecs[i].tag;
            a_in_value = vecs[i].val;
            a_squash   = vecs[i].sq;
            a_grant    = vecs[i].gr;
            #1;
            chk($sformatf("row%0d valid", i),  32'(a_valid),    32'(vecs[i].ev));
            chk($sformatf("row%0d tag", i),    32'(a_tag),      32'(vecs[i].etag));
            chk($sformatf("row%0d value", i),  a_value,         vecs[i].evalue);
            chk($sformatf("row%0d count", i),  32'(a_count),    32'(vecs[i].ecnt));
            chk($sformatf("row%0d ready", i),  32'(a_in_ready), 32'(vecs[i].erdy));
            chk($sformatf("row%0d drop", i),   32'(a_drop),     32'(vecs[i].edrop));
            chk($sformatf("row%0d urgent", i), 32'(a_urgent),   32'd0);
            step();
        end
        a_in_valid = 1'b0; a_squash = 1'b0; a_grant = 1'b0;

        // Reset mid-operation beats a same-cycle push and pop and clears the sticky error.
        a_in_valid = 1'b1; a_in_tag = 6'd30; a_in_value = vv(30);
        step();
        a_in_tag = 6'd31; a_in_value = vv(31);
        step();
        #1;
        chk("pre-reset count", 32'(a_count), 32'd2);
        a_in_tag = 6'd32; a_grant = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; a_in_valid = 1'b0; a_grant = 1'b0;
        #1;
        chk("mid-reset count", 32'(a_count), 32'd0);
        chk("mid-reset valid", 32'(a_valid), 32'd0);
        chk("mid-reset tag", 32'(a_tag), 32'd0);
        chk("mid-reset ready", 32'(a_in_ready), 32'd1);
        chk("mid-reset drop", 32'(a_drop), 32'd0);
        step();

        // Starvation: one entry held without grant.
        a_in_valid = 1'b1; a_in_tag = 6'd40; a_in_value = vv(40);
        step();
        a_in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            #1;
`ifdef FU_OUT_STARVE_EN
            chk($sformatf("urgent k=%0d", k), 32'(a_urgent), (k >= 5) ? 32'd1 : 32'd0);
`else
            chk($sformatf("urgent k=%0d", k), 32'(a_urgent), 32'd0);
`endif
            chk($sformatf("starve valid k=%0d", k), 32'(a_valid), 32'd1);
            step();
        end
`ifdef FU_OUT_STARVE_EN
        chk("urgent held", 32'(a_urgent), 32'd1);
`else
        chk("urgent held", 32'(a_urgent), 32'd0);
`endif
        a_grant = 1'b1;
        step();
        a_grant = 1'b0;
        #1;
        chk("urgent after grant", 32'(a_urgent), 32'd0);
        chk("count after grant", 32'(a_count), 32'd0);

        // Wrap-around on DEPTH=4: two pre-pushes, ten push/pop pairs, then drain.
        exp_cnt = 0;
        pops    = 0;
        for (int c = 0; c < 16; c++) begin
            do_push    = (c < 12);
            do_pop     = (c >= 2) && (exp_cnt != 0);
            b_in_valid = do_push;
            b_in_tag   = 6'(20 + c);
            b_in_value = vv(20 + c) ^ 32'h0055_0000;
            b_grant    = do_pop;
            #1;
            chk($sformatf("wrap c=%0d count", c), 32'(b_count), 32'(exp_cnt));
            chk($sformatf("wrap c=%0d valid", c), 32'(b_valid), (exp_cnt != 0) ? 32'd1 : 32'd0);
            if (do_push) chk($sformatf("wrap c=%0d ready", c), 32'(b_in_ready), 32'd1);
            if (do_pop) begin
                chk($sformatf("wrap c=%0d tag", c), 32'(b_tag), 32'(sb_tag[0]));
                chk($sformatf("wrap c=%0d value", c), b_value, sb_val[0]);
                void'(sb_tag.pop_front());
                void'(sb_val.pop_front());
                pops++;
                exp_cnt--;
            end
            if (do_push) begin
                sb_tag.push_back(b_in_tag);
                sb_val.push_back(b_in_value);
                exp_cnt++;
            end
            step();
        end
        b_in_valid = 1'b0; b_grant = 1'b0;
        #1;
        chk("wrap pops", 32'(pops), 32'd12);
        chk("wrap final count", 32'(b_count), 32'd0);
        chk("wrap drop", 32'(b_drop), 32'd0);
        chk("wrap urgent", 32'(b_urgent), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
